// File: rtl/spi_regbank_if.sv
// rtl/spi_regbank_if.sv - SPI pin bundle between an external master and the register bank
interface spi_regbank_if;
    logic sclk;
    logic cs;
    logic sdi;
    logic sdo;
    logic sdo_oe;

    modport master (output sclk, output cs, output sdi, input sdo, input sdo_oe);
    modport slave  (input sclk, input cs, input sdi, output sdo, output sdo_oe);
endinterface

// File: rtl/spi_regbank.sv
// rtl/spi_regbank.sv - oversampled SPI mode-0 slave register bank with read-back on sdo
module spi_regbank #(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    spi_regbank_if.slave               spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int SH_W    = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(ADDR_W);

    typedef enum logic [1:0] {IDLE, CMD, DATA, COMMIT} state_t;
    state_t state, state_nx;

    logic [1:0] sclk_sync, cs_sync, sdi_sync;
    logic       sclk_d, cs_d, cs_valid;
    logic       sclk_rise, sclk_fall, cs_fall, cs_rise, sample;

    logic [CNT_W-1:0]  cnt;
    logic [SH_W-1:0]   shreg;
    logic [ADDR_W:0]   cmd_bits;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] rd_sh, rd_val;
    logic              rd_loaded, addr_hit;

    // cs edge flops reset low so a frame already running at reset release never sees a falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            sdi_sync  <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
            cs_valid  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi.sclk};
            cs_sync   <= {cs_sync[0], spi.cs};
            sdi_sync  <= {sdi_sync[0], spi.sdi};
            sclk_d    <= sclk_sync[1];
            cs_d      <= cs_sync[1];
            cs_valid  <= cs_valid | cs_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_d;
    assign sclk_fall = ~sclk_sync[1] & sclk_d;
    assign cs_fall   = cs_d & ~cs_sync[1];
    assign cs_rise   = ~cs_d & cs_sync[1];
    assign sample    = sclk_rise & ~cs_sync[1];
    assign cmd_bits  = {shreg[ADDR_W-1:0], sdi_sync[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cs_fall) state_nx = CMD;
            CMD: begin
                if (cs_rise)                        state_nx = COMMIT;
                else if (sample && cnt == CNT_CMD)  state_nx = DATA;
            end
            DATA:    if (cs_rise) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_val   = '0;
        addr_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_addr == ADDR_W'(i)) begin
                rd_val   = regs_flat[i*DATA_W +: DATA_W];
                addr_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            shreg     <= '0;
            cmd_rw    <= 1'b0;
            cmd_addr  <= '0;
            rd_sh     <= '0;
            rd_loaded <= 1'b0;
            regs_flat <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (state == IDLE && cs_fall) begin
                cnt       <= '0;
                shreg     <= '0;
                rd_sh     <= '0;
                rd_loaded <= 1'b0;
            end
            if ((state == CMD || state == DATA) && sample) begin
                shreg <= {shreg[SH_W-2:0], sdi_sync[1]};
                if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                if (state == CMD && cnt == CNT_CMD) begin
                    cmd_rw   <= cmd_bits[ADDR_W];
                    cmd_addr <= cmd_bits[ADDR_W-1:0];
                end
            end
            // first falling edge in DATA snapshots the register; later ones shift zeros in behind it
            if (state == DATA && !cmd_rw && sclk_fall) begin
                if (!rd_loaded) begin
                    rd_sh     <= rd_val;
                    rd_loaded <= 1'b1;
                end else begin
                    rd_sh <= rd_sh << 1;
                end
            end
            if (state == COMMIT) begin
                if (cnt == CNT_FRAME && cmd_rw && addr_hit) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (cmd_addr == ADDR_W'(i)) regs_flat[i*DATA_W +: DATA_W] <= shreg[DATA_W-1:0];
                    end
                    wr_strobe <= 1'b1;
                    wr_addr   <= cmd_addr;
                end else if (!(cnt == CNT_FRAME && !cmd_rw)) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    assign spi.sdo    = (state == DATA) && !cmd_rw && rd_sh[DATA_W-1];
    assign spi.sdo_oe = cs_valid & ~cs_sync[1];
endmodule

// File: doc/spi_regbank.md
# spi_regbank

Parametrised SPI (mode 0) slave register bank: the next generation of the team's write-only SPI configuration peripheral. It adds a read-back path on `sdo`, and it generalises register count, data width and address width. It sits between the chip's external SPI pins and the core logic, which consumes the register contents as static configuration. All SPI inputs are asynchronous to `clk` and are oversampled.

## Interface
- `NUM_REGS`, default 5: number of implemented registers, 1..2^ADDR_W.
- `DATA_W`, default 8: register width in bits.
- `ADDR_W`, default 7: address field width.
- Derived `FRAME_W` = 1 + ADDR_W + DATA_W (16 at defaults).
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sclk`  in  1  SPI clock, asynchronous.
- `cs`  in  1  chip select, active-low, asynchronous.
- `sdi`  in  1  serial data in (MOSI), asynchronous.
- `sdo`  out  1  serial data out (MISO).
- `sdo_oe`  out  1  output enable for the `sdo` pad; high while synchronised `cs` is low.
- `regs_flat`  out  NUM_REGS*DATA_W  register contents; register i occupies bits [i*DATA_W +: DATA_W].
- `wr_strobe`  out  1  one-cycle pulse when a write commits.
- `wr_addr`  out  ADDR_W  address of the last committed write; held until the next commit.
- `frame_err`  out  1  one-cycle pulse when a frame is discarded.

## Operation
- Input synchronisation:
  - `sclk`, `cs` and `sdi` each pass through a 2-flop synchroniser clocked by `clk`.
  - Rising and falling edges of `sclk` are detected by comparing the synchronised value with its previous value.
- Frame format, MSB first:
  - Bit 0 is R/W (1 = write, 0 = read).
  - The next ADDR_W bits are the address.
  - The final DATA_W bits are the data.
- Bit sampling: `sdi` is sampled on each detected `sclk` rising edge while synchronised `cs` is low.
- FSM states are IDLE, CMD, DATA, COMMIT.
  - IDLE -> CMD on synchronised `cs` falling; the bit counter clears to 0.
  - CMD shifts in 1+ADDR_W bits, then moves to DATA.
  - In a read frame, DATA loads the read shift register on the first `sclk` falling edge after entering DATA, taking register[addr], or 0 if addr >= NUM_REGS. `sdo` then presents the data MSB.
  - Each later falling edge in DATA shifts `sdo` to the next bit.
  - DATA -> COMMIT on synchronised `cs` rising.
  - A `cs` rising while in CMD goes directly to COMMIT with the frame marked short.
  - COMMIT lasts one cycle, then the FSM returns to IDLE.
- COMMIT rules:
  - If the frame is a write, exactly FRAME_W bits were counted, and addr < NUM_REGS: load register[addr] with the data field, pulse `wr_strobe`, and update `wr_addr`.
  - If the frame is a read with exactly FRAME_W bits: no action, and no error.
  - Any other frame (short, long, or write with addr >= NUM_REGS): registers unchanged and `frame_err` pulses.
- Bit counter: width is clog2(FRAME_W+2). It saturates at FRAME_W+1 so that long frames are detectable without wrap-around.
- `sdo` levels:
  - `sdo` = 0 in IDLE, in CMD, and throughout write frames.
  - After the last data bit of a read, `sdo` holds 0.
- Reset (`rst_n` low at any time, including mid-frame):
  - All registers, `regs_flat`, `sdo`, `sdo_oe`, `wr_strobe`, `frame_err`, `wr_addr`, the counter and the shift registers go to 0.
  - The FSM goes to IDLE.
  - A frame already in progress when reset releases is ignored until the next `cs` falling edge.

## Timing
- Synchroniser latency is 2 clk. Edge detection adds 1 clk, so pin-to-action latency is 3 clk.
- `sclk` high and low phases must each be >= 4 clk periods. `sclk` period must be >= 8 clk.
- `cs` setup before the first `sclk` rising edge is >= 4 clk. `cs` hold after the last falling edge is >= 4 clk.
- `sdo` changes 3 clk after the `sclk` falling edge at the pin. It is therefore stable for the master's next rising-edge sample.
- COMMIT occurs 3 clk after `cs` rises at the pin. `regs_flat` updates, and `wr_strobe` pulses high, in the same cycle, 4 clk after `cs` rises.
- Read data is a snapshot taken at load time. A write committing during a read frame does not alter the bits already loaded.
- Back-to-back frames: `cs` may fall again once COMMIT has completed, i.e. >= 5 clk after the previous `cs` rise.

## Test plan
- Reset, then write 0x8_1A5 (reg1 = 0xA5): `regs_flat[15:8]` = 0xA5, one `wr_strobe` pulse, `wr_addr` = 1, all other registers remain 0.
- Write reg4 = 0x3C, then read frame 0x04_00: `sdo` bits during the data phase are 0,0,1,1,1,1,0,0; `sdo_oe` is high only while `cs` is low; no `frame_err`.
- Write to addr 5 (0x85_FF), a 15-bit frame, and a 17-bit frame: each produces one `frame_err` pulse; `regs_flat` is unchanged; no `wr_strobe`.
- Read from addr 9: `sdo` = 0 for all data bits; no `frame_err`.
- Assert `rst_n` low after 8 bits of a write frame: outputs are 0 immediately; the remaining bits and the `cs` rise cause no commit; the next full frame writes correctly.
- Non-default build NUM_REGS=3, DATA_W=12, ADDR_W=2 (FRAME_W = 15): write reg2 = 0xABC, read it back; reg2 holds 0xABC and `sdo` returns 0xABC MSB first.
